// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-port Memory with a registered read and a negedge write.
// Define MEM_ARB_FIXED_PRIO_EN to give port B fixed priority instead of round-robin.

module mem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 128
) (
   input  logic              clk,
   input  logic              rst,
   // Handshake: a requester holds req (and its addr/data) until its ack. The request is
   // captured on the edge that grants it; ack is a 1-cycle pulse with rdata/err valid only then.
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_err,
   output logic              busy,
   output logic              mem_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_w_data,
   input  logic [DATA_W-1:0] m_r_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t            state_q;
   logic              grant_b_q;
   logic              we_q;
   logic              a_ack_q;
   logic              b_ack_q;
   logic              b_err_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_w_data_q;
   logic [DATA_W-1:0] hold_q;

   logic              any_req;
   logic              pick_b;
   logic              pick_we;
   logic [ADDR_W-1:0] pick_addr;
   logic              b_out_of_range;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign pick_b = b_req;
`else
   logic last_grant_b_q;
   // Round-robin: on a tie the port that was not granted last time wins.
   assign pick_b = b_req & (~a_req | ~last_grant_b_q);
`endif

   assign any_req        = a_req | b_req;
   assign pick_we        = pick_b & b_we;
   assign pick_addr      = pick_b ? b_addr : a_addr;
   assign b_out_of_range = (b_addr >= ADDR_W'(MEM_DEPTH));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         grant_b_q   <= 1'b0;
         we_q        <= 1'b0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         b_err_q     <= 1'b0;
         mem_write_q <= 1'b0;
         m_addr_q    <= '0;
         m_w_data_q  <= '0;
         hold_q      <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
         last_grant_b_q <= 1'b1;
`endif
      end else begin
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         b_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_b_q <= pick_b;
                  we_q      <= pick_we;
                  hold_q    <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                  last_grant_b_q <= pick_b;
`endif
                  if (pick_b && b_out_of_range) begin
                     // Error path never touches the Memory bus.
                     state_q <= RESP;
                     b_ack_q <= 1'b1;
                     b_err_q <= 1'b1;
                  end else begin
                     state_q     <= ISSUE;
                     m_addr_q    <= pick_addr;
                     mem_write_q <= pick_we;
                     m_w_data_q  <= pick_we ? b_wdata : '0;
                  end
               end
            end
            ISSUE: begin
               m_addr_q    <= '0;
               mem_write_q <= 1'b0;
               m_w_data_q  <= '0;
               if (we_q) begin
                  state_q <= RESP;
                  a_ack_q <= ~grant_b_q;
                  b_ack_q <= grant_b_q;
               end else begin
                  state_q <= CAPTURE;
               end
            end
            CAPTURE: begin
               hold_q  <= m_r_data;
               state_q <= RESP;
               a_ack_q <= ~grant_b_q;
               b_ack_q <= grant_b_q;
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign b_err     = b_err_q;
   assign a_rdata   = a_ack_q ? hold_q : '0;
   assign b_rdata   = b_ack_q ? hold_q : '0;
   assign busy      = (state_q != IDLE);
   assign mem_write = mem_write_q;
   assign m_addr    = m_addr_q;
   assign m_w_data  = m_w_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural Memory plus scenario tasks with an expected-data queue.
// Expectations follow MEM_ARB_FIXED_PRIO_EN when it is defined for the build.

module tb_mem_port_arbiter;

   localparam int W = 32;
`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         a_req = 1'b0;
   logic [W-1:0] a_addr = '0;
   logic         a_ack;
   logic [W-1:0] a_rdata;
   logic         b_req = 1'b0;
   logic         b_we = 1'b0;
   logic [W-1:0] b_addr = '0;
   logic [W-1:0] b_wdata = '0;
   logic         b_ack;
   logic [W-1:0] b_rdata;
   logic         b_err;
   logic         busy;
   logic         mem_write;
   logic [W-1:0] m_addr;
   logic [W-1:0] m_w_data;
   logic [W-1:0] m_r_data = '0;

   logic [W-1:0] mem [0:127];
   logic [W-1:0] exp_q[$];
   logic         exp_port_q[$];
   int           errors = 0;
   int           checks = 0;

   mem_port_arbiter #(.ADDR_W(W), .DATA_W(W), .MEM_DEPTH(128)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err), .busy(busy),
      .mem_write(mem_write), .m_addr(m_addr), .m_w_data(m_w_data), .m_r_data(m_r_data)
   );

   // clock / memory model
   always #5 clk = ~clk;

   initial for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + W'(i);

   always @(posedge clk) m_r_data <= (m_addr < 128) ? mem[m_addr[6:0]] : '0;
   always @(negedge clk) if (mem_write && m_addr < 128) mem[m_addr[6:0]] <= m_w_data;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_req = 1'b0;
      b_req = 1'b0;
      b_we  = 1'b0;
   endtask

   task automatic wait_ack(output int lat);
      lat = 0;
      while (lat < 12) begin
         tick();
         lat++;
         if (a_ack || b_ack) break;
      end
   endtask

   // scenarios
   task automatic test_reset();
      int lat;
      logic [W-1:0] got, exp_d;
      logic exp_p;
      rst = 1'b0; a_req = 1'b1; b_req = 1'b1; a_addr = 3; b_addr = 4; b_we = 1'b0;
      tick(); tick();
      checks++; if ({a_ack, b_ack, b_err, busy, mem_write} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 00000", {a_ack, b_ack, b_err, busy, mem_write}); end
      checks++; if (a_rdata !== '0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 0", a_rdata); end
      checks++; if (b_rdata !== '0) begin errors++; $display("FAIL reset_b_rdata: got %h expected 0", b_rdata); end
      checks++; if (m_addr !== '0) begin errors++; $display("FAIL reset_m_addr: got %h expected 0", m_addr); end
      checks++; if (m_w_data !== '0) begin errors++; $display("FAIL reset_m_w_data: got %h expected 0", m_w_data); end
      exp_port_q.push_back(FIXED);
      exp_q.push_back(FIXED ? 32'h1000_0004 : 32'h1000_0003);
      rst = 1'b1;
      wait_ack(lat);
      exp_p = exp_port_q.pop_front();
      exp_d = exp_q.pop_front();
      got = b_ack ? b_rdata : a_rdata;
      checks++; if (lat !== 3) begin errors++; $display("FAIL first_grant_latency: got %0d expected 3", lat); end
      checks++; if (b_ack !== exp_p) begin errors++; $display("FAIL first_grant_port: got b=%b expected b=%b", b_ack, exp_p); end
      checks++; if (got !== exp_d) begin errors++; $display("FAIL first_grant_data: got %h expected %h", got, exp_d); end
      idle_inputs();
      tick();
   endtask

   task automatic test_write_read();
      int lat;
      b_req = 1'b1; b_we = 1'b1; b_addr = 5; b_wdata = 32'hDEAD_BEEF;
      exp_q.push_back('0);
      tick();
      checks++; if (mem_write !== 1'b1 || m_addr !== 5 || m_w_data !== 32'hDEAD_BEEF) begin errors++;
         $display("FAIL wr_issue: got we=%b addr=%h data=%h expected we=1 addr=5 data=deadbeef", mem_write, m_addr, m_w_data); end
      checks++; if (b_ack !== 1'b0 || busy !== 1'b1) begin errors++;
         $display("FAIL wr_issue_state: got ack=%b busy=%b expected ack=0 busy=1", b_ack, busy); end
      idle_inputs();
      tick();
      checks++; if (b_ack !== 1'b1 || b_err !== 1'b0) begin errors++;
         $display("FAIL wr_ack: got ack=%b err=%b expected ack=1 err=0", b_ack, b_err); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL wr_resp_mem_write: got %b expected 0", mem_write); end
      checks++; if (b_rdata !== exp_q[0]) begin errors++; $display("FAIL wr_rdata: got %h expected %h", b_rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
      a_req = 1'b1; a_addr = 5;
      exp_q.push_back(32'hDEAD_BEEF);
      wait_ack(lat);
      checks++; if (lat !== 3 || a_ack !== 1'b1) begin errors++;
         $display("FAIL raw_latency: got lat=%0d a_ack=%b expected lat=3 a_ack=1", lat, a_ack); end
      checks++; if (a_rdata !== exp_q[0]) begin errors++; $display("FAIL raw_data: got %h expected %h", a_rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      idle_inputs();
      tick();
   endtask

   task automatic test_round_robin();
      int lat;
      logic last_b, pick, exp_p;
      logic [W-1:0] got, exp_d;
      last_b = 1'b0;
      for (int n = 0; n < 4; n++) begin
         pick = FIXED ? 1'b1 : ~last_b;
         last_b = pick;
         exp_port_q.push_back(pick);
         exp_q.push_back(pick ? 32'h1000_0002 : 32'h1000_0001);
      end
      a_req = 1'b1; a_addr = 1; b_req = 1'b1; b_addr = 2; b_we = 1'b0;
      for (int n = 0; n < 4; n++) begin
         wait_ack(lat);
         exp_p = exp_port_q.pop_front();
         exp_d = exp_q.pop_front();
         got = b_ack ? b_rdata : a_rdata;
         checks++; if (lat !== ((n == 0) ? 3 : 4)) begin errors++;
            $display("FAIL rr_gap_%0d: got %0d expected %0d", n, lat, (n == 0) ? 3 : 4); end
         checks++; if ({a_ack, b_ack} !== {~exp_p, exp_p}) begin errors++;
            $display("FAIL rr_port_%0d: got a=%b b=%b expected b=%b", n, a_ack, b_ack, exp_p); end
         checks++; if (got !== exp_d) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", n, got, exp_d); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_out_of_range();
      int lat;
      logic [W-1:0] addrs [2];
      addrs[0] = 32'd128;
      addrs[1] = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         b_req = 1'b1; b_we = (i == 1); b_addr = addrs[i]; b_wdata = 32'h5555_AAAA;
         tick();
         checks++; if (b_ack !== 1'b1 || b_err !== 1'b1) begin errors++;
            $display("FAIL oor_ack_%0d: got ack=%b err=%b expected 1 1", i, b_ack, b_err); end
         checks++; if (b_rdata !== '0 || mem_write !== 1'b0 || m_addr !== '0) begin errors++;
            $display("FAIL oor_bus_%0d: got rdata=%h we=%b addr=%h expected all 0", i, b_rdata, mem_write, m_addr); end
         idle_inputs();
         tick();
      end
      b_req = 1'b1; b_we = 1'b0; b_addr = 127;
      exp_q.push_back(32'h1000_007F);
      wait_ack(lat);
      checks++; if (lat !== 3 || b_ack !== 1'b1 || b_err !== 1'b0) begin errors++;
         $display("FAIL edge_addr_ack: got lat=%0d ack=%b err=%b expected 3 1 0", lat, b_ack, b_err); end
      checks++; if (b_rdata !== exp_q[0]) begin errors++; $display("FAIL edge_addr_data: got %h expected %h", b_rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      idle_inputs();
      tick();
   endtask

   task automatic test_latch();
      int lat;
      logic [W-1:0] raddr [2];
      raddr[0] = 7;
      raddr[1] = 9;
      b_req = 1'b1; b_we = 1'b1; b_addr = 7; b_wdata = 32'h1234_5678;
      tick();
      b_addr = 9; b_wdata = 32'h0BAD_0BAD; b_req = 1'b0;
      checks++; if (m_addr !== 7 || m_w_data !== 32'h1234_5678) begin errors++;
         $display("FAIL latch_issue: got addr=%h data=%h expected 7 12345678", m_addr, m_w_data); end
      tick();
      checks++; if (b_ack !== 1'b1) begin errors++; $display("FAIL latch_ack: got %b expected 1", b_ack); end
      idle_inputs();
      tick();
      exp_q.push_back(32'h1234_5678);
      exp_q.push_back(32'h1000_0009);
      for (int i = 0; i < 2; i++) begin
         a_req = 1'b1; a_addr = raddr[i];
         wait_ack(lat);
         checks++; if (lat !== 3 || a_rdata !== exp_q[0]) begin errors++;
            $display("FAIL latch_read_%0d: got lat=%0d data=%h expected 3 %h", i, lat, a_rdata, exp_q[0]); end
         void'(exp_q.pop_front());
         idle_inputs();
         tick();
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int stray;
      a_req = 1'b1; a_addr = 10;
      tick();
      a_req = 1'b0;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || a_ack !== 1'b0) begin errors++;
         $display("FAIL abort_now: got busy=%b ack=%b expected 0 0", busy, a_ack); end
      tick();
      rst = 1'b1;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_ack || b_ack || busy) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d active cycles expected 0", stray); end
      a_req = 1'b1; a_addr = 10;
      exp_q.push_back(32'h1000_000A);
      wait_ack(lat);
      checks++; if (lat !== 3 || a_ack !== 1'b1 || a_rdata !== exp_q[0]) begin errors++;
         $display("FAIL abort_recover: got lat=%0d ack=%b data=%h expected 3 1 %h", lat, a_ack, a_rdata, exp_q[0]); end
      void'(exp_q.pop_front());
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_out_of_range();
      test_latch();
      test_reset_abort();
      checks++; if (exp_q.size() !== 0) begin errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
